// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// Preset mm:ss countdown timer. It counts down once per 1 Hz `pulse` tick from
// a loaded value and flags expiry when the count reaches 00:00. It drives the
// same four BCD digit outputs as the stopwatch time handler, so one display
// path can show either block.
//
// Parameters:
//   SIZE    width of each BCD digit
//   TIME_U  largest value a units digit may take (9)
//   TIME_T  largest value a tens digit may take (5)
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   pulse                    1 Hz tick enable, one clk cycle wide
//   load + set_*             capture a preset mm:ss value
//   start / pause / clear    run control
//   minutes_* / seconds_*    remaining time, registered BCD digits
//   running                  high while counting (RUN)
//   expired                  high once the count has reached 00:00 (EXPIRED)
//   expired_pulse            one-cycle strobe on entry to EXPIRED
//   load_err                 one-cycle strobe when a preset is rejected
//   dbg_state                current FSM state:
//                            0 IDLE, 1 RUN, 2 PAUSED, 3 EXPIRED
//
// Command semantics: the control inputs are level-sampled commands, not a
// valid/ready handshake. Every input is sampled on each rising clk edge and
// its effect is visible right after that edge. When several commands are
// high in one cycle, only the highest-priority one counts:
//   clear > load > pause > start > pulse
// The winner is chosen among the asserted inputs before checking whether it
// is legal in the current state. A losing command is dropped, not queued for
// later.
// -----------------------------------------------------------------------------
module countdown_timer #(
    parameter int SIZE   = 4,
    parameter int TIME_U = 9,
    parameter int TIME_T = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pulse,
    input  logic            load,
    input  logic [SIZE-1:0] set_minutes_tens,
    input  logic [SIZE-1:0] set_minutes_units,
    input  logic [SIZE-1:0] set_seconds_tens,
    input  logic [SIZE-1:0] set_seconds_units,
    input  logic            start,
    input  logic            pause,
    input  logic            clear,
    output logic [SIZE-1:0] minutes_tens,
    output logic [SIZE-1:0] minutes_units,
    output logic [SIZE-1:0] seconds_tens,
    output logic [SIZE-1:0] seconds_units,
    output logic            running,
    output logic            expired,
    output logic            expired_pulse,
    output logic            load_err,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [SIZE-1:0] MAX_U = SIZE'(TIME_U);
    localparam logic [SIZE-1:0] MAX_T = SIZE'(TIME_T);
    localparam logic [SIZE-1:0] ZERO  = '0;
    localparam logic [SIZE-1:0] ONE   = SIZE'(1);

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    state_t          state_q;
    logic [SIZE-1:0] mt_q, mu_q, st_q, su_q;
    logic            expired_pulse_q;
    logic            load_err_q;

    // Next-state values
    state_t          state_d;
    logic [SIZE-1:0] mt_d, mu_d, st_d, su_d;
    logic            expired_pulse_d;
    logic            load_err_d;

    // -------------------------------------------------------------------------
    // BCD decrement by a borrow chain. A digit at zero wraps to its maximum
    // and passes the borrow to the next digit up. The minutes-tens borrow is
    // never used, because RUN only ever holds a non-zero count.
    // -------------------------------------------------------------------------
    logic [SIZE-1:0] dec_mt, dec_mu, dec_st, dec_su;
    logic            borrow_su, borrow_st, borrow_mu;
    logic            count_zero;
    logic            dec_zero;

    always_comb begin
        borrow_su = (su_q == ZERO);
        dec_su    = borrow_su ? MAX_U : su_q - ONE;

        borrow_st = borrow_su && (st_q == ZERO);
        if (borrow_su) begin
            dec_st = (st_q == ZERO) ? MAX_T : st_q - ONE;
        end else begin
            dec_st = st_q;
        end

        borrow_mu = borrow_st && (mu_q == ZERO);
        if (borrow_st) begin
            dec_mu = (mu_q == ZERO) ? MAX_U : mu_q - ONE;
        end else begin
            dec_mu = mu_q;
        end

        if (borrow_mu) begin
            dec_mt = (mt_q == ZERO) ? MAX_T : mt_q - ONE;
        end else begin
            dec_mt = mt_q;
        end

        count_zero = (mt_q == ZERO) && (mu_q == ZERO) &&
                     (st_q == ZERO) && (su_q == ZERO);
        dec_zero   = (dec_mt == ZERO) && (dec_mu == ZERO) &&
                     (dec_st == ZERO) && (dec_su == ZERO);
    end

    // A preset is valid only if every digit is within range for its position.
    logic preset_ok;

    always_comb begin
        preset_ok = (set_minutes_tens  <= MAX_T) &&
                    (set_minutes_units <= MAX_U) &&
                    (set_seconds_tens  <= MAX_T) &&
                    (set_seconds_units <= MAX_U);
    end

    // -------------------------------------------------------------------------
    // Process 1: state register (FSM state, digits and strobes)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            mt_q            <= ZERO;
            mu_q            <= ZERO;
            st_q            <= ZERO;
            su_q            <= ZERO;
            expired_pulse_q <= 1'b0;
            load_err_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            mt_q            <= mt_d;
            mu_q            <= mu_d;
            st_q            <= st_d;
            su_q            <= su_d;
            expired_pulse_q <= expired_pulse_d;
            load_err_q      <= load_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Process 2: next-state logic. The if/else chain sets command priority.
    // The strobes default to 0, so each one can last only a single cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        mt_d            = mt_q;
        mu_d            = mu_q;
        st_d            = st_q;
        su_d            = su_q;
        expired_pulse_d = 1'b0;
        load_err_d      = 1'b0;

        if (clear) begin
            state_d = IDLE;
            mt_d    = ZERO;
            mu_d    = ZERO;
            st_d    = ZERO;
            su_d    = ZERO;
        end else if (load) begin
            // A running count cannot be overwritten; load must come after
            // a pause (or before start / after expiry).
            if (state_q != RUN) begin
                if (preset_ok) begin
                    state_d = IDLE;
                    mt_d    = set_minutes_tens;
                    mu_d    = set_minutes_units;
                    st_d    = set_seconds_tens;
                    su_d    = set_seconds_units;
                end else begin
                    load_err_d = 1'b1;
                end
            end
        end else if (pause) begin
            if (state_q == RUN) begin
                state_d = PAUSED;
            end
        end else if (start) begin
            // A zero count would expire without ever being shown, so
            // start is refused at 00:00.
            if ((state_q == IDLE || state_q == PAUSED) && !count_zero) begin
                state_d = RUN;
            end
        end else if (pulse) begin
            if (state_q == RUN) begin
                mt_d = dec_mt;
                mu_d = dec_mu;
                st_d = dec_st;
                su_d = dec_su;
                if (dec_zero) begin
                    state_d         = EXPIRED;
                    expired_pulse_d = 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Process 3: outputs, decoded straight from the registers
    // -------------------------------------------------------------------------
    always_comb begin
        minutes_tens  = mt_q;
        minutes_units = mu_q;
        seconds_tens  = st_q;
        seconds_units = su_q;
        running       = (state_q == RUN);
        expired       = (state_q == EXPIRED);
        expired_pulse = expired_pulse_q;
        load_err      = load_err_q;
        dbg_state     = state_q;
    end

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
//
// Drives commands one clk cycle at a time. A reference model keeps the
// remaining time as a plain count of seconds and turns it into mm:ss digits.
// Each cycle the expected output word is pushed to exp_q and then popped and
// compared once the DUT has updated.
//
// Observed word layout (22 bits):
//   [21:6] mt, mu, st, su digits
//   [5] running  [4] expired  [3] expired_pulse  [2] load_err
//   [1:0] dbg_state
// -----------------------------------------------------------------------------
module tb_countdown_timer;

    localparam int W = 22;

    // Command vector bits: {clear, load, pause, start, pulse}
    localparam logic [4:0] C_NONE  = 5'b00000;
    localparam logic [4:0] C_PULSE = 5'b00001;
    localparam logic [4:0] C_START = 5'b00010;
    localparam logic [4:0] C_PAUSE = 5'b00100;
    localparam logic [4:0] C_LOAD  = 5'b01000;
    localparam logic [4:0] C_CLEAR = 5'b10000;

    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_EXPIRED = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       pulse, load, start, pause, clear;
    logic [3:0] set_minutes_tens, set_minutes_units;
    logic [3:0] set_seconds_tens, set_seconds_units;
    logic [3:0] minutes_tens, minutes_units, seconds_tens, seconds_units;
    logic       running, expired, expired_pulse, load_err;
    logic [1:0] dbg_state;

    logic [W-1:0] exp_q[$];
    int vectors = 0;
    int errors  = 0;

    // Reference model state
    int m_secs;
    int m_state;
    bit m_epulse;
    bit m_lerr;

    countdown_timer #(.SIZE(4), .TIME_U(9), .TIME_T(5)) dut (
        .clk               (clk),
        .rst               (rst),
        .pulse             (pulse),
        .load              (load),
        .set_minutes_tens  (set_minutes_tens),
        .set_minutes_units (set_minutes_units),
        .set_seconds_tens  (set_seconds_tens),
        .set_seconds_units (set_seconds_units),
        .start             (start),
        .pause             (pause),
        .clear             (clear),
        .minutes_tens      (minutes_tens),
        .minutes_units     (minutes_units),
        .seconds_tens      (seconds_tens),
        .seconds_units     (seconds_units),
        .running           (running),
        .expired           (expired),
        .expired_pulse     (expired_pulse),
        .load_err          (load_err),
        .dbg_state         (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d%0d:%0d%0d run=%0b exp=%0b ep=%0b le=%0b st=%0d, expected %0d%0d:%0d%0d run=%0b exp=%0b ep=%0b le=%0b st=%0d",
                     tag, got[21:18], got[17:14], got[13:10], got[9:6], got[5], got[4], got[3], got[2], got[1:0],
                     exp[21:18], exp[17:14], exp[13:10], exp[9:6], exp[5], exp[4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    function automatic logic [W-1:0] dut_word();
        return {minutes_tens, minutes_units, seconds_tens, seconds_units,
                running, expired, expired_pulse, load_err, dbg_state};
    endfunction

    function automatic logic [W-1:0] model_word();
        logic [3:0] mt, mu, st, su;
        mt = 4'(m_secs / 600);
        mu = 4'((m_secs / 60) % 10);
        st = 4'((m_secs % 60) / 10);
        su = 4'(m_secs % 10);
        return {mt, mu, st, su, (m_state == S_RUN), (m_state == S_EXPIRED),
                m_epulse, m_lerr, 2'(m_state)};
    endfunction

    task automatic model_reset();
        m_secs   = 0;
        m_state  = S_IDLE;
        m_epulse = 1'b0;
        m_lerr   = 1'b0;
    endtask

    // Reference model: one cycle, highest-priority asserted command wins.
    task automatic model_step(input logic [4:0] cmd, input logic [15:0] preset);
        int pmt, pmu, pst, psu;
        pmt = int'(preset[15:12]);
        pmu = int'(preset[11:8]);
        pst = int'(preset[7:4]);
        psu = int'(preset[3:0]);
        m_epulse = 1'b0;
        m_lerr   = 1'b0;
        if (cmd[4]) begin
            m_secs  = 0;
            m_state = S_IDLE;
        end else if (cmd[3]) begin
            if (m_state != S_RUN) begin
                if (pmt <= 5 && pmu <= 9 && pst <= 5 && psu <= 9) begin
                    m_secs  = pmt * 600 + pmu * 60 + pst * 10 + psu;
                    m_state = S_IDLE;
                end else begin
                    m_lerr = 1'b1;
                end
            end
        end else if (cmd[2]) begin
            if (m_state == S_RUN) m_state = S_PAUSED;
        end else if (cmd[1]) begin
            if ((m_state == S_IDLE || m_state == S_PAUSED) && m_secs != 0) m_state = S_RUN;
        end else if (cmd[0]) begin
            if (m_state == S_RUN) begin
                m_secs = m_secs - 1;
                if (m_secs == 0) begin
                    m_state  = S_EXPIRED;
                    m_epulse = 1'b1;
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    // Drive at the falling edge, let the rising edge capture, check 1 ns later.
    task automatic step(input string tag, input logic [4:0] cmd, input logic [15:0] preset);
        @(negedge clk);
        {clear, load, pause, start, pulse} = cmd;
        {set_minutes_tens, set_minutes_units, set_seconds_tens, set_seconds_units} = preset;
        model_step(cmd, preset);
        exp_q.push_back(model_word());
        @(posedge clk);
        #1;
        check(tag, dut_word(), exp_q.pop_front());
        {clear, load, pause, start, pulse} = C_NONE;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        {clear, load, pause, start, pulse} = C_NONE;
        {set_minutes_tens, set_minutes_units, set_seconds_tens, set_seconds_units} = 16'h0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(model_word());
        check("reset_state", dut_word(), exp_q.pop_front());
        @(negedge clk);
        rst = 1'b0;

        // Countdown to expiry from 00:03
        step("load_0003",  C_LOAD,  16'h0003);
        step("start_0003", C_START, 16'h0000);
        step("pulse_0002", C_PULSE, 16'h0000);
        step("pulse_0001", C_PULSE, 16'h0000);
        step("pulse_0000", C_PULSE, 16'h0000);
        step("exp_hold",   C_NONE,  16'h0000);
        step("start_in_expired", C_START, 16'h0000);
        step("pulse_in_expired", C_PULSE, 16'h0000);

        // Zero start and clear
        step("clear_expired", C_CLEAR, 16'h0000);
        step("start_at_zero", C_START, 16'h0000);

        // Borrow chain: 10:00 -> 09:59, then 01:00 -> 00:59
        step("load_1000",  C_LOAD,  16'h1000);
        step("start_1000", C_START | C_PULSE, 16'h0000);
        step("pulse_0959", C_PULSE, 16'h0000);
        step("pause_0959", C_PAUSE, 16'h0000);
        step("load_0100",  C_LOAD,  16'h0100);
        step("start_0100", C_START, 16'h0000);
        step("pulse_0059", C_PULSE, 16'h0000);

        // Invalid preset rejected, digits unchanged
        step("pause_0059",   C_PAUSE, 16'h0000);
        step("load_bad_0761", C_LOAD, 16'h0761);
        step("load_err_off",  C_NONE, 16'h0000);
        step("load_bad_mt",   C_LOAD, 16'h6000);
        step("load_bad_su",   C_LOAD, 16'h000A);

        // Pause and resume from 05:30
        step("load_0531",   C_LOAD,  16'h0531);
        step("start_0531",  C_START, 16'h0000);
        step("pulse_0530",  C_PULSE, 16'h0000);
        step("pause_pulse", C_PAUSE | C_PULSE, 16'h0000);
        for (int i = 0; i < 3; i++) step("paused_pulse", C_PULSE, 16'h0000);
        step("resume",      C_START, 16'h0000);
        step("pulse_0529",  C_PULSE, 16'h0000);

        // Load ignored in RUN, then clear beats load
        step("load_in_run", C_LOAD, 16'h0123);
        step("clear_load",  C_CLEAR | C_LOAD, 16'h0123);

        // Asynchronous reset mid-RUN at 12:34
        step("load_1234",  C_LOAD,  16'h1234);
        step("start_1234", C_START, 16'h0000);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        exp_q.push_back(model_word());
        check("async_reset", dut_word(), exp_q.pop_front());
        @(posedge clk);
        #1;
        exp_q.push_back(model_word());
        check("reset_held", dut_word(), exp_q.pop_front());
        @(negedge clk);
        rst = 1'b0;
        step("after_reset", C_NONE, 16'h0000);
        step("start_after_reset", C_START, 16'h0000);

        // Random traffic: mostly pulses and starts, occasional other commands
        for (int i = 0; i < 400; i++) begin
            logic [4:0]  cmd;
            logic [15:0] preset;
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 50)      cmd = C_PULSE;
            else if (r < 62) cmd = C_START;
            else if (r < 70) cmd = C_PAUSE;
            else if (r < 80) cmd = C_LOAD;
            else if (r < 83) cmd = C_CLEAR;
            else if (r < 90) cmd = 5'($urandom_range(0, 31));
            else             cmd = C_NONE;
            preset[15:12] = 4'($urandom_range(0, 6));
            preset[11:8]  = 4'($urandom_range(0, 9));
            preset[7:4]   = 4'($urandom_range(0, 6));
            preset[3:0]   = 4'($urandom_range(0, 10));
            // Keep counts short so expiry is reached often
            if ($urandom_range(0, 3) != 0) preset[15:4] = 12'h000;
            step("random", cmd, preset);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
